// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC bus sweeper:
//   - estado_t     : bus FSM states
//   - tipo_tr_t    : kind of transaction in flight (sweep read, user write,
//                    internal transfer command)
//   - register index constants and the index -> RTC address table
//   - transfer-command address/data and the POSICION value used for writes
// -----------------------------------------------------------------------------
package rtc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIR     = 3'd1,
        PAUSA   = 3'd2,
        DATO_RD = 3'd3,
        DATO_WR = 3'd4,
        RECUP   = 3'd5
    } estado_t;

    typedef enum logic [1:0] {
        TR_LECTURA   = 2'd0,
        TR_ESCRITURA = 2'd1,
        TR_COMANDO   = 2'd2
    } tipo_tr_t;

    // Register indices as seen on POSICION
    localparam logic [3:0] IDX_SEG    = 4'd0;
    localparam logic [3:0] IDX_MIN    = 4'd1;
    localparam logic [3:0] IDX_HORA   = 4'd2;
    localparam logic [3:0] IDX_DIA    = 4'd3;
    localparam logic [3:0] IDX_MES    = 4'd4;
    localparam logic [3:0] IDX_ANIO   = 4'd5;
    localparam logic [3:0] IDX_T_SEG  = 4'd6;
    localparam logic [3:0] IDX_T_MIN  = 4'd7;
    localparam logic [3:0] IDX_T_HORA = 4'd8;
    localparam logic [3:0] IDX_ULTIMO = IDX_T_HORA;

    localparam logic [7:0] DIR_CMD_TRANSF     = 8'hF0;
    localparam logic [7:0] DATO_CMD_TRANSF    = 8'h00;
    localparam logic [3:0] POSICION_ESCRITURA = 4'hF;

    // Index -> RTC register address
    function automatic logic [7:0] dir_registro(input logic [3:0] idx);
        logic [7:0] dir;
        case (idx)
            IDX_SEG:    dir = 8'h21;
            IDX_MIN:    dir = 8'h22;
            IDX_HORA:   dir = 8'h23;
            IDX_DIA:    dir = 8'h24;
            IDX_MES:    dir = 8'h25;
            IDX_ANIO:   dir = 8'h26;
            IDX_T_SEG:  dir = 8'h41;
            IDX_T_MIN:  dir = 8'h42;
            IDX_T_HORA: dir = 8'h43;
            default:    dir = 8'h21;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/rtc_temporizador_fase.sv
// -----------------------------------------------------------------------------
// rtc_temporizador_fase
// Loadable down-counter that times one bus phase. Loading value N makes the
// phase last N+1 cycles; fase_fin_o is high in the last one (count = 0).
// Ports:
//   reloj_i     clock
//   reset_n_i   synchronous active-low reset
//   carga_i     load valor_i this cycle (state entry)
//   valor_i     cycles-minus-one of the phase being entered
//   cuenta_o    current count, lets the FSM see the next-to-last cycle
//   fase_fin_o  high in the last cycle of the phase
// -----------------------------------------------------------------------------
module rtc_temporizador_fase (
    input  logic       reloj_i,
    input  logic       reset_n_i,
    input  logic       carga_i,
    input  logic [7:0] valor_i,
    output logic [7:0] cuenta_o,
    output logic       fase_fin_o
);

    logic [7:0] cuenta_q;
    logic [7:0] cuenta_d;

    // Next count: load, else count down and rest at zero
    always_comb begin
        cuenta_d = cuenta_q;
        if (carga_i) begin
            cuenta_d = valor_i;
        end else if (cuenta_q != 8'd0) begin
            cuenta_d = cuenta_q - 8'd1;
        end else begin
            cuenta_d = cuenta_q;
        end
    end

    // Count register
    always_ff @(posedge reloj_i) begin
        if (!reset_n_i) begin
            cuenta_q <= 8'd0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o   = cuenta_q;
    assign fase_fin_o = (cuenta_q == 8'd0);

endmodule

// File: rtl/rtc_bus_barrido.sv
// -----------------------------------------------------------------------------
// rtc_bus_barrido
// Owns the multiplexed address/data bus of the external RTC. Periodically
// sweeps the nine time/date/timer registers, pulsing READ with POSICION set
// while the RTC drives the read byte, and performs single-register writes
// requested by the control side.
//
// Parameters:
//   T_FASE           cycles per bus phase (address, data, recovery), 2..255
//   PERIODO_BARRIDO  cycles between sweep starts
//
// Ports:
//   reloj, resetM          clock, synchronous active-low reset
//   DIR_DATO               RTC address/data bus (high-Z unless driven here)
//   CS_n, RD_n, WR_n, A_D  RTC strobes; A_D = 0 address phase, 1 data phase
//   POSICION               register index of the current read, 0xF on writes
//   READ                   one-cycle pulse, DIR_DATO holds read data
//   wr_req/wr_dir/wr_dato  write request (held until wr_ack), address, data
//   wr_ack                 one-cycle pulse when a write completes
//   ocupado                high while a bus transaction is in progress
//
// Build option:
//   COMANDO_TRANSFERENCIA_EN  when defined, every sweep begins with an
//                             internal write of 0x00 to address 0xF0.
// -----------------------------------------------------------------------------
module rtc_bus_barrido
    import rtc_pkg::*;
#(
    parameter int T_FASE          = 10,
    parameter int PERIODO_BARRIDO = 1_000_000
) (
    input  logic       reloj,
    input  logic       resetM,
    inout  wire  [7:0] DIR_DATO,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A_D,
    output logic [3:0] POSICION,
    output logic       READ,
    input  logic       wr_req,
    input  logic [7:0] wr_dir,
    input  logic [7:0] wr_dato,
    output logic       wr_ack,
    output logic       ocupado
);

    localparam logic [7:0]   FASE_ULT = 8'(T_FASE - 1);
    localparam int           TW       = (PERIODO_BARRIDO > 1) ? $clog2(PERIODO_BARRIDO) : 1;
    localparam logic [TW-1:0] TMR_ULT = TW'(PERIODO_BARRIDO - 1);

    // FSM and transaction context
    estado_t    estado_q;
    tipo_tr_t   tipo_q;
    logic [3:0] idx_q;
    logic       en_barrido_q;    // a sweep is in progress; idx_q is its next read
    logic [7:0] dato_q;

    // Registered outputs
    logic       cs_n_q, rd_n_q, wr_n_q, a_d_q;
    logic [7:0] bus_q;
    logic       bus_oe_q;
    logic [3:0] posicion_q;
    logic       read_q, wr_ack_q, ocupado_q;

    // Sweep timer
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    logic          envuelve_s;

    // Decision signals
    logic       arranque_s;
    logic       consume_pend_s;
    tipo_tr_t   tipo_nuevo_s;
    logic [3:0] idx_nuevo_s;
    logic       en_nuevo_s;
    logic [7:0] dir_nueva_s;

    // Phase counter interface
    logic       carga_s;
    logic [7:0] valor_s;
    logic [7:0] cuenta_s;
    logic       fase_fin_s;

    rtc_temporizador_fase u_fase (
        .reloj_i    (reloj),
        .reset_n_i  (resetM),
        .carga_i    (carga_s),
        .valor_i    (valor_s),
        .cuenta_o   (cuenta_s),
        .fase_fin_o (fase_fin_s)
    );

    // Transaction scheduling: decided in IDLE and in the last RECUP cycle
    always_comb begin
        arranque_s     = 1'b0;
        consume_pend_s = 1'b0;
        tipo_nuevo_s   = tipo_q;
        idx_nuevo_s    = idx_q;
        en_nuevo_s     = en_barrido_q;
        if (estado_q == IDLE) begin
            if (wr_req) begin
                arranque_s   = 1'b1;
                tipo_nuevo_s = TR_ESCRITURA;
            end else if (pend_q) begin
                consume_pend_s = 1'b1;
                arranque_s     = 1'b1;
                idx_nuevo_s    = IDX_SEG;
                en_nuevo_s     = 1'b1;
`ifdef COMANDO_TRANSFERENCIA_EN
                tipo_nuevo_s   = TR_COMANDO;
`else
                tipo_nuevo_s   = TR_LECTURA;
`endif
            end else begin
                arranque_s = 1'b0;
            end
        end else if ((estado_q == RECUP) && fase_fin_s) begin
            // Advance the sweep past the read that just finished
            if (tipo_q == TR_LECTURA) begin
                if (idx_q < IDX_ULTIMO) begin
                    idx_nuevo_s = idx_q + 4'd1;
                end else begin
                    en_nuevo_s = 1'b0;
                end
            end else begin
                idx_nuevo_s = idx_q;
            end
            // wr_req is still high in the ack cycle of a user write, so it
            // must not be taken as a new request right after that write.
            if (wr_req && (tipo_q != TR_ESCRITURA)) begin
                arranque_s   = 1'b1;
                tipo_nuevo_s = TR_ESCRITURA;
            end else if (en_nuevo_s) begin
                arranque_s   = 1'b1;
                tipo_nuevo_s = TR_LECTURA;
            end else begin
                arranque_s = 1'b0;
            end
        end else begin
            arranque_s = 1'b0;
        end
    end

    // Address placed on the bus for the transaction being started
    always_comb begin
        case (tipo_nuevo_s)
            TR_ESCRITURA: dir_nueva_s = wr_dir;
            TR_COMANDO:   dir_nueva_s = DIR_CMD_TRANSF;
            TR_LECTURA:   dir_nueva_s = dir_registro(idx_nuevo_s);
            default:      dir_nueva_s = dir_registro(idx_nuevo_s);
        endcase
    end

    // Phase counter reload on every state entry; PAUSA is a single cycle
    always_comb begin
        carga_s = 1'b0;
        valor_s = FASE_ULT;
        case (estado_q)
            IDLE:    carga_s = arranque_s;
            DIR: begin
                carga_s = fase_fin_s;
                valor_s = 8'd0;
            end
            PAUSA:   carga_s = fase_fin_s;
            DATO_RD: carga_s = fase_fin_s;
            DATO_WR: carga_s = fase_fin_s;
            RECUP:   carga_s = arranque_s;
            default: carga_s = 1'b0;
        endcase
    end

    // Sweep timer next state; a wrap re-arms the pending flag even if it is
    // being consumed in the same cycle, so no period is lost
    always_comb begin
        envuelve_s = (tmr_q == TMR_ULT);
        tmr_d      = envuelve_s ? {TW{1'b0}} : (tmr_q + TW'(1));
        if (envuelve_s) begin
            pend_d = 1'b1;
        end else if (consume_pend_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Sweep timer and pending flag registers
    always_ff @(posedge reloj) begin
        if (!resetM) begin
            tmr_q  <= {TW{1'b0}};
            pend_q <= 1'b1;
        end else begin
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
        end
    end

    // Bus FSM with registered strobes, bus drive and status outputs
    always_ff @(posedge reloj) begin
        if (!resetM) begin
            estado_q     <= IDLE;
            tipo_q       <= TR_LECTURA;
            idx_q        <= 4'd0;
            en_barrido_q <= 1'b0;
            dato_q       <= 8'h00;
            cs_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            a_d_q        <= 1'b0;
            bus_q        <= 8'h00;
            bus_oe_q     <= 1'b0;
            posicion_q   <= 4'd0;
            read_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            idx_q        <= idx_nuevo_s;
            en_barrido_q <= en_nuevo_s;
            read_q       <= 1'b0;
            wr_ack_q     <= 1'b0;
            if (arranque_s) begin
                estado_q   <= DIR;
                tipo_q     <= tipo_nuevo_s;
                cs_n_q     <= 1'b0;
                rd_n_q     <= 1'b1;
                wr_n_q     <= 1'b0;
                a_d_q      <= 1'b0;
                bus_q      <= dir_nueva_s;
                bus_oe_q   <= 1'b1;
                dato_q     <= (tipo_nuevo_s == TR_ESCRITURA) ? wr_dato : DATO_CMD_TRANSF;
                posicion_q <= (tipo_nuevo_s == TR_LECTURA) ? idx_nuevo_s : POSICION_ESCRITURA;
                ocupado_q  <= 1'b1;
            end else begin
                case (estado_q)
                    IDLE: begin
                        estado_q <= IDLE;
                    end
                    DIR: begin
                        if (fase_fin_s) begin
                            estado_q <= PAUSA;
                            cs_n_q   <= 1'b1;
                            wr_n_q   <= 1'b1;
                            bus_oe_q <= 1'b0;
                        end
                    end
                    PAUSA: begin
                        if (fase_fin_s) begin
                            cs_n_q <= 1'b0;
                            a_d_q  <= 1'b1;
                            if (tipo_q == TR_LECTURA) begin
                                estado_q <= DATO_RD;
                                rd_n_q   <= 1'b0;
                            end else begin
                                estado_q <= DATO_WR;
                                wr_n_q   <= 1'b0;
                                bus_q    <= dato_q;
                                bus_oe_q <= 1'b1;
                            end
                        end
                    end
                    DATO_RD: begin
                        // Set one cycle early so the pulse lands on the last cycle
                        read_q <= (cuenta_s == 8'd1);
                        if (fase_fin_s) begin
                            estado_q <= RECUP;
                            cs_n_q   <= 1'b1;
                            rd_n_q   <= 1'b1;
                            a_d_q    <= 1'b0;
                        end
                    end
                    DATO_WR: begin
                        if (fase_fin_s) begin
                            estado_q <= RECUP;
                            cs_n_q   <= 1'b1;
                            wr_n_q   <= 1'b1;
                            a_d_q    <= 1'b0;
                            bus_oe_q <= 1'b0;
                        end
                    end
                    RECUP: begin
                        wr_ack_q <= (tipo_q == TR_ESCRITURA) && (cuenta_s == 8'd1);
                        if (fase_fin_s) begin
                            estado_q  <= IDLE;
                            ocupado_q <= 1'b0;
                        end
                    end
                    default: begin
                        estado_q  <= IDLE;
                        cs_n_q    <= 1'b1;
                        rd_n_q    <= 1'b1;
                        wr_n_q    <= 1'b1;
                        a_d_q     <= 1'b0;
                        bus_oe_q  <= 1'b0;
                        ocupado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DIR_DATO = bus_oe_q ? bus_q : 8'hzz;
    assign CS_n     = cs_n_q;
    assign RD_n     = rd_n_q;
    assign WR_n     = wr_n_q;
    assign A_D      = a_d_q;
    assign POSICION = posicion_q;
    assign READ     = read_q;
    assign wr_ack   = wr_ack_q;
    assign ocupado  = ocupado_q;

endmodule

// File: tb/tb_rtc_bus_barrido.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_barrido
// Directed bench for rtc_bus_barrido with T_FASE=4 (13-cycle transactions).
// Instance dut  : PERIODO_BARRIDO=2000, attached to a small RTC bus model.
// Instance dut_b: PERIODO_BARRIDO=50, sweeps run back to back; its READ
//                 pulses are followed for index order and spacing.
// -----------------------------------------------------------------------------
module tb_rtc_bus_barrido;

    localparam int TF = 4;
`ifdef COMANDO_TRANSFERENCIA_EN
    localparam int         OFS         = 13;
    localparam logic [7:0] PRIMERA_DIR = 8'hF0;
    localparam logic [3:0] PRIMERA_POS = 4'hF;
`else
    localparam int         OFS         = 0;
    localparam logic [7:0] PRIMERA_DIR = 8'h21;
    localparam logic [3:0] PRIMERA_POS = 4'h0;
`endif
    localparam int GAP_B = 14 + OFS;

    logic reloj = 1'b0;
    always #5 reloj = ~reloj;

    int ciclo = 0;
    always @(posedge reloj) ciclo <= ciclo + 1;

    // Main instance
    logic       resetM, wr_req, CS_n, RD_n, WR_n, A_D, READ, wr_ack, ocupado;
    logic [7:0] wr_dir, wr_dato;
    logic [3:0] POSICION;
    wire  [7:0] DIR_DATO;

    rtc_bus_barrido #(.T_FASE(TF), .PERIODO_BARRIDO(2000)) dut (
        .reloj(reloj), .resetM(resetM), .DIR_DATO(DIR_DATO),
        .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A_D(A_D),
        .POSICION(POSICION), .READ(READ),
        .wr_req(wr_req), .wr_dir(wr_dir), .wr_dato(wr_dato),
        .wr_ack(wr_ack), .ocupado(ocupado)
    );

    // Short-period instance
    logic       b_rst, b_cs_n, b_rd_n, b_wr_n, b_a_d, b_read, b_ack, b_ocup;
    logic [3:0] b_pos;
    wire  [7:0] b_bus;

    rtc_bus_barrido #(.T_FASE(TF), .PERIODO_BARRIDO(50)) dut_b (
        .reloj(reloj), .resetM(b_rst), .DIR_DATO(b_bus),
        .CS_n(b_cs_n), .RD_n(b_rd_n), .WR_n(b_wr_n), .A_D(b_a_d),
        .POSICION(b_pos), .READ(b_read),
        .wr_req(1'b0), .wr_dir(8'h00), .wr_dato(8'h00),
        .wr_ack(b_ack), .ocupado(b_ocup)
    );

    // RTC model: latches the address in the address phase, stores write
    // data, drives the addressed byte while RD_n is low
    logic [7:0] mem [256];
    logic [7:0] rtc_dir = 8'h00;
    logic       sonda   = 1'b0;
    logic [7:0] tabla [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    assign DIR_DATO = (!CS_n && !RD_n) ? mem[rtc_dir] : 8'hzz;
    // Probe: a released bus reads back this pattern
    assign DIR_DATO = sonda ? 8'h5A : 8'hzz;

    always @(posedge reloj) begin
        if (!CS_n && !WR_n && !A_D) rtc_dir <= DIR_DATO;
        if (!CS_n && !WR_n && A_D) mem[rtc_dir] <= DIR_DATO;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_ack = 0;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_chk++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observado=0x%0h esperado=0x%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    always @(negedge reloj) if (wr_ack) n_ack <= n_ack + 1;

    // Follow the short-period instance: indices 0..8 cyclic, fixed spacing
    int         b_n   = 0;
    int         b_t   = 0;
    logic [3:0] b_esp = 4'd0;
    always @(negedge reloj) begin
        if (b_read) begin
            comprobar("b_pos", b_pos, b_esp);
            if (b_n > 0) begin
                if (b_esp == 4'd0) comprobar("b_gap_barrido", ciclo - b_t, GAP_B);
                else               comprobar("b_gap", ciclo - b_t, 13);
            end
            b_esp <= (b_esp == 4'd8) ? 4'd0 : b_esp + 4'd1;
            b_t   <= ciclo;
            b_n   <= b_n + 1;
        end
    end

    function automatic logic cond(input int modo);
        case (modo)
            0:       return !CS_n && !WR_n && !A_D;
            1:       return !CS_n && !WR_n && A_D;
            2:       return wr_ack;
            default: return !ocupado;
        endcase
    endfunction

    task automatic esperar(input int modo, input string tag);
        int k = 0;
        @(negedge reloj);
        while (!cond(modo) && k < 3000) begin
            @(negedge reloj);
            k++;
        end
        comprobar(tag, {31'd0, cond(modo)}, 32'd1);
    endtask

    task automatic esperar_read(output logic [3:0] pos, output logic [7:0] dato, output int t);
        int k = 0;
        @(negedge reloj);
        while (!READ && k < 3000) begin
            @(negedge reloj);
            k++;
        end
        comprobar("timeout_read", {31'd0, READ}, 32'd1);
        comprobar("read_rd_n", RD_n, 1'b0);
        pos  = POSICION;
        dato = DIR_DATO;
        t    = ciclo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulacion sin terminar en t=%0t, limite 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] pos;
        logic [7:0] dato;
        int t, t_prev, t3, c0;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h59; mem[8'h22] = 8'h12; mem[8'h23] = 8'h08;
        mem[8'h24] = 8'h17; mem[8'h25] = 8'h06; mem[8'h26] = 8'h24;
        mem[8'h41] = 8'h33; mem[8'h42] = 8'h44; mem[8'h43] = 8'h55;

        resetM = 1'b0; b_rst = 1'b0; wr_req = 1'b0; wr_dir = 8'h00; wr_dato = 8'h00;
        repeat (3) @(negedge reloj);

        // Reset state
        sonda = 1'b1;
        #1;
        comprobar("rst_cs_n", CS_n, 1'b1);
        comprobar("rst_rd_n", RD_n, 1'b1);
        comprobar("rst_wr_n", WR_n, 1'b1);
        comprobar("rst_a_d", A_D, 1'b0);
        comprobar("rst_bus_libre", DIR_DATO, 8'h5A);
        comprobar("rst_read", READ, 1'b0);
        comprobar("rst_wr_ack", wr_ack, 1'b0);
        comprobar("rst_ocupado", ocupado, 1'b0);
        comprobar("rst_posicion", POSICION, 4'd0);
        sonda = 1'b0;

        // Release: first address phase starts on the next edge
        @(negedge reloj);
        c0 = ciclo;
        resetM = 1'b1;
        b_rst  = 1'b1;
        @(negedge reloj);
        comprobar("dir1_cs_n", CS_n, 1'b0);
        comprobar("dir1_wr_n", WR_n, 1'b0);
        comprobar("dir1_a_d", A_D, 1'b0);
        comprobar("dir1_bus", DIR_DATO, PRIMERA_DIR);
        comprobar("dir1_pos", POSICION, PRIMERA_POS);
        comprobar("dir1_ocupado", ocupado, 1'b1);
`ifdef COMANDO_TRANSFERENCIA_EN
        esperar(1, "cmd_fase_dato");
        comprobar("cmd_dato_bus", DIR_DATO, 8'h00);
        comprobar("cmd_pos", POSICION, 4'hF);
`endif

        // Sweep 1: nine reads, 13 cycles apart
        t_prev = 0;
        for (int i = 0; i < 9; i++) begin
            esperar_read(pos, dato, t);
            comprobar("s1_pos", pos, i);
            comprobar("s1_dato", dato, mem[tabla[i]]);
            if (i == 0) comprobar("s1_latencia", t - c0, 9 + OFS);
            else        comprobar("s1_gap", t - t_prev, 13);
            t_prev = t;
        end
        // Busy through cycle 117 (+OFS), idle on 118
        repeat (4) @(negedge reloj);
        comprobar("s1_ocupado_fin", ocupado, 1'b1);
        @(negedge reloj);
        comprobar("s1_ocupado_baja", ocupado, 1'b0);
        comprobar("s1_ocupado_ciclo", ciclo - c0, 118 + OFS);

        // Sweep 2: write requested during index 3
        for (int i = 0; i < 4; i++) begin
            esperar_read(pos, dato, t);
            comprobar("s2_pos", pos, i);
        end
        t3 = t;
        wr_dir = 8'h22; wr_dato = 8'h30; wr_req = 1'b1;
        esperar(0, "wr_fase_dir");
        comprobar("wr_inicio", ciclo - t3, 5);
        comprobar("wr_dir_bus", DIR_DATO, 8'h22);
        comprobar("wr_dir_pos", POSICION, 4'hF);
        wr_dir = 8'h00; wr_dato = 8'h00;
        esperar(1, "wr_fase_dato");
        comprobar("wr_dato_bus", DIR_DATO, 8'h30);
        comprobar("wr_dato_pos", POSICION, 4'hF);
        esperar(2, "wr_ack_llega");
        comprobar("wr_ack_ciclo", ciclo - t3, 17);
        wr_req = 1'b0;
        for (int i = 4; i < 9; i++) begin
            esperar_read(pos, dato, t);
            comprobar("s2_pos", pos, i);
            comprobar("s2_dato", dato, mem[tabla[i]]);
            if (i == 4) comprobar("s2_reanuda_gap", t - t3, 26);
        end
        esperar(3, "s2_fin");
        comprobar("s2_n_ack", n_ack, 1);
        comprobar("rtc_reg_escrito", mem[8'h22], 8'h30);

        // Reset during a write data phase
        @(negedge reloj);
        wr_dir = 8'h41; wr_dato = 8'h07; wr_req = 1'b1;
        esperar(1, "r_fase_dato_wr");
        resetM = 1'b0;
        wr_req = 1'b0;
        @(negedge reloj);
        sonda = 1'b1;
        #1;
        comprobar("r_cs_n", CS_n, 1'b1);
        comprobar("r_rd_n", RD_n, 1'b1);
        comprobar("r_wr_n", WR_n, 1'b1);
        comprobar("r_bus_libre", DIR_DATO, 8'h5A);
        comprobar("r_wr_ack", wr_ack, 1'b0);
        comprobar("r_ocupado", ocupado, 1'b0);
        sonda = 1'b0;
        repeat (3) @(negedge reloj);
        comprobar("r_sin_ack", n_ack, 1);
        c0 = ciclo;
        resetM = 1'b1;
        @(negedge reloj);
        comprobar("r_dir_bus", DIR_DATO, PRIMERA_DIR);
        comprobar("r_dir_pos", POSICION, PRIMERA_POS);
        esperar_read(pos, dato, t);
        comprobar("r_barrido_pos", pos, 4'd0);
        comprobar("r_barrido_lat", t - c0, 9 + OFS);
        comprobar("r_sin_ack_fin", n_ack, 1);

        // Short-period instance kept sweeping throughout
        comprobar("b_lecturas_min", {31'd0, (b_n >= 18)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_barrido.md
Name: rtc_bus_barrido

Overview:
- Upstream stage of the VGA graphics top. Owns the multiplexed address/data bus (DIR_DATO) of the external RTC chip.
- Periodically sweeps the nine time/date/timer registers. For each register it releases the bus during the read data phase and pulses READ with POSICION set, so the display's number renderer can latch the byte off DIR_DATO.
- Also performs single-register writes on request from the control side (PicoBlaze port logic).

Parameters:
- T_FASE, 10: clock cycles per bus phase (address, data, recovery); legal range 2..255.
- PERIODO_BARRIDO, 1_000_000: cycles between sweep starts (10 ms at 100 MHz).

Ports:
- reloj  in  1  system clock.
- resetM  in  1  synchronous, active-low reset.
- DIR_DATO  inout  8  RTC multiplexed address/data bus; high-Z except when this block drives it.
- CS_n  out  1  RTC chip select, active low.
- RD_n  out  1  RTC read strobe, active low.
- WR_n  out  1  RTC write strobe, active low.
- A_D  out  1  0 = address phase, 1 = data phase.
- POSICION  out  4  register index 0..8 of the current read; 0xF during writes.
- READ  out  1  one-cycle pulse; DIR_DATO holds valid read data in that cycle.
- wr_req  in  1  write request; held high until wr_ack.
- wr_dir  in  8  write register address; sampled when the write is accepted.
- wr_dato  in  8  write data; sampled when the write is accepted.
- wr_ack  out  1  one-cycle pulse at completion of a write.
- ocupado  out  1  high while any bus transaction is in progress.

Behaviour:
- Reset (resetM=0 at a rising edge), applied on the next edge regardless of state:
  - CS_n=RD_n=WR_n=1, A_D=0, DIR_DATO high-Z.
  - READ=0, wr_ack=0, ocupado=0, POSICION=0.
  - Sweep timer=0, sweep-pending flag=1, so the first sweep starts right after reset.
- Register map (index -> address): 0:0x21 seg, 1:0x22 min, 2:0x23 hora, 3:0x24 dia, 4:0x25 mes, 5:0x26 año, 6:0x41 t_seg, 7:0x42 t_min, 8:0x43 t_hora.
- FSM states: IDLE, DIR, PAUSA, DATO_RD, DATO_WR, RECUP.
- Transaction timing, phase counter reloaded at every state entry:
  - DIR: T_FASE cycles. CS_n=0, WR_n=0, A_D=0, bus driven with the address.
  - PAUSA: 1 cycle. All strobes high, bus high-Z.
  - DATO_RD: T_FASE cycles. CS_n=0, RD_n=0, A_D=1, bus high-Z. READ=1 only on the last cycle.
  - DATO_WR: T_FASE cycles. CS_n=0, WR_n=0, A_D=1, bus driven with data.
  - RECUP: T_FASE cycles. All strobes high, bus high-Z. wr_ack=1 on its last cycle if the transaction was a write.
  - Total per transaction: 3*T_FASE+1 cycles. ocupado=1 in every state except IDLE.
- Sweep sequencing:
  - Sweep timer free-runs and wraps at PERIODO_BARRIDO-1; on wrap it sets the pending flag (saturating, one pending sweep at most).
  - IDLE with flag set: clear flag, index=0, start a read.
  - After each read RECUP: if index<8, increment and start the next read; index 8 ends the sweep and returns to IDLE.
- Write arbitration:
  - wr_req is checked in IDLE and at the end of every RECUP. It preempts the next sweep read; the sweep resumes at the same index afterwards.
  - If a write and the sweep flag are both pending in IDLE, the write goes first.
  - wr_dir and wr_dato are latched on acceptance. POSICION=0xF for the whole write.
  - wr_req deasserted before wr_ack: the write still completes and wr_ack still pulses.
- POSICION updates on entry to DIR and holds through RECUP.
- The bus is never driven in the cycle adjacent to RD_n low; PAUSA guarantees the turnaround.

Optional Feature:
- Macro COMANDO_TRANSFERENCIA_EN.
- Defined: every sweep is preceded by an internal write of 0x00 to address 0xF0 (RTC transfer command), same timing as DATO_WR. It has POSICION=0xF and no wr_ack. A sweep then costs 10 transactions.
- Undefined: sweeps contain only the nine reads.

Decomposition:
- Shared package rtc_pkg holds:
  - State enum.
  - Register address table and index constants.
  - Transfer-command address/data (0xF0/0x00).
  - POSICION_ESCRITURA=4'hF.
- One natural sub-module, rtc_temporizador_fase: loadable down-counter producing a fase_fin pulse, instanced for the phase counter. The sweep timer stays inline.

Test Plan:
- Reset release, T_FASE=4, PERIODO_BARRIDO=2000 -> first DIR starts 1 cycle later with bus=0x21; READ pulses 9 times, 13 cycles apart, POSICION 0..8; ocupado low after 117 cycles.
- RTC model returns 0x59 at 0x21 -> READ cycle shows DIR_DATO=0x59, POSICION=0, RD_n=0.
- wr_req with wr_dir=0x22, wr_dato=0x30 mid-sweep at index 3 -> write follows index 3's RECUP with POSICION=0xF and bus=0x22 then 0x30; wr_ack pulses once; sweep resumes at index 4.
- resetM low during DATO_WR -> next edge all strobes=1, bus high-Z, no wr_ack; after release a fresh sweep starts at index 0.
- PERIODO_BARRIDO=50 (shorter than a sweep) -> pending flag saturates; sweeps run back to back with no lost or duplicated index.
- COMANDO_TRANSFERENCIA_EN defined -> each sweep begins with bus=0xF0 then 0x00 with WR_n low, before the read at 0x21.
